// File: rtl/ips2l_pcie_dma_rx_mwr_wr_ctrl_if.sv
// ---------------------------------------------------------------------------
// ips2l_pcie_dma_rx_mwr_wr_ctrl_if
// Bundles the RX MWr payload handshake (from RX TLP decode) and the BAR RAM
// write port of ips2l_pcie_dma_rx_mwr_wr_ctrl.
//   i_wr_start/i_wr_addr/i_wr_length/i_first_be/i_last_be : burst header
//   i_wr_valid/i_wr_data/o_wr_ready                       : payload beats
//   o_wr_busy/o_wr_done/o_wr_err                          : burst status
//   o_bar_wr_en/o_bar_wr_addr/o_bar_wr_byte_en/o_bar_wr_data : BAR RAM write
// master : the side that drives the header/payload (decoder or bench)
// slave  : the write controller
// ---------------------------------------------------------------------------
interface ips2l_pcie_dma_rx_mwr_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                    i_wr_start;
    logic [ADDR_WIDTH+1:0]   i_wr_addr;
    logic [9:0]              i_wr_length;
    logic [3:0]              i_first_be;
    logic [3:0]              i_last_be;
    logic                    i_wr_valid;
    logic [127:0]            i_wr_data;
    logic                    o_wr_ready;
    logic                    o_wr_busy;
    logic                    o_wr_done;
    logic                    o_wr_err;
    logic                    o_bar_wr_en;
    logic [ADDR_WIDTH-1:0]   o_bar_wr_addr;
    logic [15:0]             o_bar_wr_byte_en;
    logic [127:0]            o_bar_wr_data;

    modport master (
        output i_wr_start, i_wr_addr, i_wr_length, i_first_be, i_last_be,
               i_wr_valid, i_wr_data,
        input  o_wr_ready, o_wr_busy, o_wr_done, o_wr_err,
               o_bar_wr_en, o_bar_wr_addr, o_bar_wr_byte_en, o_bar_wr_data
    );

    modport slave (
        input  i_wr_start, i_wr_addr, i_wr_length, i_first_be, i_last_be,
               i_wr_valid, i_wr_data,
        output o_wr_ready, o_wr_busy, o_wr_done, o_wr_err,
               o_bar_wr_en, o_bar_wr_addr, o_bar_wr_byte_en, o_bar_wr_data
    );
endinterface

// File: rtl/ips2l_pcie_dma_rx_mwr_wr_ctrl.sv
// ---------------------------------------------------------------------------
// ips2l_pcie_dma_rx_mwr_wr_ctrl
// Receive-side MWr payload writer. Takes DW-packed 128-bit payload beats
// (beat i carries DW 4i..4i+3 in lanes 0..3), shifts them up to the DW lane
// offset of the start address and writes 128-bit words into the BAR RAM with
// per-byte enables derived from first_be/last_be.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of ips2l_pcie_dma_rx_mwr_wr_ctrl_if
//            header (start/addr/length/BEs), payload (valid/data/ready),
//            status (busy/done/err) and RAM write port (en/addr/byte_en/data)
// All outputs are registered; a RAM word appears one cycle after the beat
// that completes it. When the lane offset pushes the tail of the payload
// into one more word than there were beats, a single FLUSH cycle writes
// that last word from the hold register.
// ---------------------------------------------------------------------------
module ips2l_pcie_dma_rx_mwr_wr_ctrl #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                           clk,
    input  logic                           rst_n,
    ips2l_pcie_dma_rx_mwr_wr_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    // Word assembly: lane l of the output word takes current-beat lane l-off
    // when l>=off, otherwise previous-beat lane l+4-off (the DWs that spilled
    // over from the previous beat).
    function automatic logic [127:0] f_realign(
        input logic [127:0] cur,
        input logic [127:0] prev,
        input logic [1:0]   off
    );
        logic [127:0] res;
        res = 128'd0;
        for (int l = 0; l < 4; l++) begin
            if (l >= int'(off)) begin
                res[32*l +: 32] = cur[32*(l-int'(off)) +: 32];
            end else begin
                res[32*l +: 32] = prev[32*(l+4-int'(off)) +: 32];
            end
        end
        return res;
    endfunction

    // Byte enables of one word. kbase is the payload DW index carried by
    // lane 0 (4*word - offset, negative for the first word when off>0).
    // The k==0 test comes first so a 1-DW payload only uses first_be.
    function automatic logic [15:0] f_lane_be(
        input logic signed [12:0] kbase,
        input logic [10:0]        len,
        input logic [3:0]         first_be,
        input logic [3:0]         last_be
    );
        logic [15:0]       be;
        logic signed [13:0] k;
        logic signed [13:0] slen;
        be   = 16'h0000;
        slen = $signed({3'b000, len});
        for (int l = 0; l < 4; l++) begin
            k = {kbase[12], kbase} + 14'(l);
            if ((k < 14'sd0) || (k >= slen)) begin
                be[4*l +: 4] = 4'h0;
            end else if (k == 14'sd0) begin
                be[4*l +: 4] = first_be;
            end else if (k == (slen - 14'sd1)) begin
                be[4*l +: 4] = last_be;
            end else begin
                be[4*l +: 4] = 4'hF;
            end
        end
        return be;
    endfunction

    // Burst context
    state_t                  r_state;
    logic [10:0]             r_len;
    logic [1:0]              r_off;
    logic [3:0]              r_first_be;
    logic [3:0]              r_last_be;
    logic [8:0]              r_beats;
    logic [8:0]              r_beat_cnt;
    logic                    r_flush;
    logic [ADDR_WIDTH-1:0]   r_waddr;
    logic signed [12:0]      r_kbase;
    logic [127:0]            r_hold;

    // Registered outputs
    logic                    r_ready;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err;
    logic                    r_wr_en;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [15:0]             r_wr_byte_en;
    logic [127:0]            r_wr_data;

    // Header decode and per-cycle helpers
    logic [10:0]             w_len_in;
    logic [1:0]              w_off_in;
    logic [10:0]             w_beat_sum;
    logic [10:0]             w_word_sum;
    logic [8:0]              w_beats_in;
    logic [8:0]              w_words_in;
    logic                    w_flush_in;
    logic                    w_beat_acc;
    logic                    w_last_beat;
    logic                    w_err;
    logic [127:0]            w_beat_word;
    logic [127:0]            w_flush_word;
    logic [15:0]             w_word_be;

    // A length field of 0 encodes 1024 DW; all sums fit in 11 bits.
    assign w_len_in     = (bus.i_wr_length == 10'd0) ? 11'd1024 : {1'b0, bus.i_wr_length};
    assign w_off_in     = bus.i_wr_addr[1:0];
    assign w_beat_sum   = w_len_in + 11'd3;
    assign w_word_sum   = w_len_in + {9'd0, w_off_in} + 11'd3;
    assign w_beats_in   = w_beat_sum[10:2];
    assign w_words_in   = w_word_sum[10:2];
    assign w_flush_in   = (w_words_in > w_beats_in);

    assign w_beat_acc   = (r_state == ST_DATA) && bus.i_wr_valid;
    assign w_last_beat  = (r_beat_cnt == (r_beats - 9'd1));
    assign w_err        = (bus.i_wr_start && (r_state != ST_IDLE)) ||
                          (bus.i_wr_valid && (r_state != ST_DATA));

    assign w_beat_word  = f_realign(bus.i_wr_data, r_hold, r_off);
    assign w_flush_word = f_realign(128'd0, r_hold, r_off);
    assign w_word_be    = f_lane_be(r_kbase, r_len, r_first_be, r_last_be);

    // Burst FSM with hold register, counters and all registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_len        <= 11'd0;
            r_off        <= 2'd0;
            r_first_be   <= 4'h0;
            r_last_be    <= 4'h0;
            r_beats      <= 9'd0;
            r_beat_cnt   <= 9'd0;
            r_flush      <= 1'b0;
            r_waddr      <= '0;
            r_kbase      <= 13'sd0;
            r_hold       <= 128'd0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_byte_en <= 16'h0000;
            r_wr_data    <= 128'd0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= w_err;
            // busy drops the cycle after done; a start accepted in that same
            // cycle overrides this below and keeps it high
            if (r_done) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.i_wr_start) begin
                        r_len      <= w_len_in;
                        r_off      <= w_off_in;
                        r_first_be <= bus.i_first_be;
                        r_last_be  <= bus.i_last_be;
                        r_beats    <= w_beats_in;
                        r_beat_cnt <= 9'd0;
                        r_flush    <= w_flush_in;
                        r_waddr    <= bus.i_wr_addr[ADDR_WIDTH+1:2];
                        r_kbase    <= -$signed({11'd0, w_off_in});
                        r_hold     <= 128'd0;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_DATA;
                    end else begin
                        r_ready    <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                ST_DATA: begin
                    if (w_beat_acc) begin
                        r_wr_en      <= 1'b1;
                        r_wr_addr    <= r_waddr;
                        r_wr_byte_en <= w_word_be;
                        r_wr_data    <= w_beat_word;
                        r_hold       <= bus.i_wr_data;
                        r_waddr      <= r_waddr + ADDR_ONE;
                        r_kbase      <= r_kbase + 13'sd4;
                        r_beat_cnt   <= r_beat_cnt + 9'd1;
                        if (w_last_beat) begin
                            r_ready <= 1'b0;
                            if (r_flush) begin
                                r_state <= ST_FLUSH;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_ready <= 1'b1;
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= ST_DATA;
                    end
                end

                ST_FLUSH: begin
                    // Tail DWs of the last beat, still in the hold register
                    r_wr_en      <= 1'b1;
                    r_wr_addr    <= r_waddr;
                    r_wr_byte_en <= w_word_be;
                    r_wr_data    <= w_flush_word;
                    r_waddr      <= r_waddr + ADDR_ONE;
                    r_kbase      <= r_kbase + 13'sd4;
                    r_done       <= 1'b1;
                    r_ready      <= 1'b0;
                    r_state      <= ST_IDLE;
                end

                default: begin
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_wr_ready       = r_ready;
    assign bus.o_wr_busy        = r_busy;
    assign bus.o_wr_done        = r_done;
    assign bus.o_wr_err         = r_err;
    assign bus.o_bar_wr_en      = r_wr_en;
    assign bus.o_bar_wr_addr    = r_wr_addr;
    assign bus.o_bar_wr_byte_en = r_wr_byte_en;
    assign bus.o_bar_wr_data    = r_wr_data;

endmodule

// File: tb/tb_ips2l_pcie_dma_rx_mwr_wr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ips2l_pcie_dma_rx_mwr_wr_ctrl
// Directed and randomized bursts against a word-level reference model: the
// expected RAM image of a burst is derived from the DW start address, length
// and byte enables, and every output cycle is compared with it.
// ---------------------------------------------------------------------------
module tb_ips2l_pcie_dma_rx_mwr_wr_ctrl;

    localparam int AW = 9;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    ips2l_pcie_dma_rx_mwr_wr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    ips2l_pcie_dma_rx_mwr_wr_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ready"},   128'(bus.o_wr_ready),       128'd0);
        chk({tag, "_busy"},    128'(bus.o_wr_busy),        128'd0);
        chk({tag, "_done"},    128'(bus.o_wr_done),        128'd0);
        chk({tag, "_err"},     128'(bus.o_wr_err),         128'd0);
        chk({tag, "_wr_en"},   128'(bus.o_bar_wr_en),      128'd0);
        chk({tag, "_addr"},    128'(bus.o_bar_wr_addr),    128'd0);
        chk({tag, "_byte_en"}, 128'(bus.o_bar_wr_byte_en), 128'd0);
        chk({tag, "_data"},    bus.o_bar_wr_data,          128'd0);
    endtask

    task automatic drive_idle();
        bus.i_wr_start  = 1'b0;
        bus.i_wr_addr   = '0;
        bus.i_wr_length = 10'd0;
        bus.i_first_be  = 4'h0;
        bus.i_last_be   = 4'h0;
        bus.i_wr_valid  = 1'b0;
        bus.i_wr_data   = 128'd0;
    endtask

    // One complete burst with per-cycle checking against the reference model.
    task automatic run_burst(input string nm, input logic [10:0] addr, input logic [9:0] lenf,
                             input logic [3:0] fbe, input logic [3:0] lbe, input int gap_pct,
                             input bit inj_start, input bit valid_w_start);
        int len, o, base, beats, words, flush;
        int sent, wrote, gaps, it, done_it, k;
        bit v, exp_en, exp_err, pend, inj_now, injd;
        logic [31:0]  dw[];
        logic [8:0]   ea[$];
        logic [15:0]  eb[$];
        logic [127:0] ed[$];
        logic [127:0] em[$];
        logic [15:0]  be;
        logic [127:0] d, m, bd;

        len   = (lenf == 10'd0) ? 1024 : int'(lenf);
        o     = int'(addr[1:0]);
        base  = int'(addr[10:2]);
        beats = (len + 3) / 4;
        words = (o + len + 3) / 4;
        flush = (words > beats) ? 1 : 0;
        dw = new[beats * 4];
        foreach (dw[i]) dw[i] = $urandom;

        // Expected RAM image: lane l of word j holds payload DW 4j+l-o
        for (int j = 0; j < words; j++) begin
            be = 16'h0000; d = 128'd0; m = 128'd0;
            for (int l = 0; l < 4; l++) begin
                k = 4 * j + l - o;
                if (k >= 0 && k < len) begin
                    d[32*l +: 32] = dw[k];
                    m[32*l +: 32] = 32'hFFFF_FFFF;
                    if (k == 0)            be[4*l +: 4] = fbe;
                    else if (k == len - 1) be[4*l +: 4] = lbe;
                    else                   be[4*l +: 4] = 4'hF;
                end
            end
            for (int b = 0; b < 16; b++) if (!be[b]) m[8*b +: 8] = 8'h00;
            ea.push_back(9'((base + j) % (1 << AW)));
            eb.push_back(be);
            ed.push_back(d & m);
            em.push_back(m);
        end

        @(posedge clk); #1;
        bus.i_wr_start  = 1'b1;
        bus.i_wr_addr   = addr;
        bus.i_wr_length = lenf;
        bus.i_first_be  = fbe;
        bus.i_last_be   = lbe;
        bus.i_wr_valid  = valid_w_start;
        bus.i_wr_data   = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;

        sent = 0; wrote = 0; gaps = 0; it = 0; done_it = -1;
        exp_en = 1'b0; exp_err = valid_w_start; pend = 1'b0; injd = 1'b0;
        while (wrote < words && it < 3000) begin
            inj_now = inj_start && !injd && (sent == 1) && (sent < beats);
            if (inj_now) injd = 1'b1;
            bus.i_wr_start  = inj_now;
            bus.i_wr_addr   = ~addr;
            bus.i_wr_length = 10'd3;
            if (sent < beats) begin
                v = (gap_pct == 0) || ($urandom_range(0, 99) >= gap_pct);
                if (!v) gaps++;
            end else begin
                v = 1'b0;
            end
            bd = 128'd0;
            if (v) for (int n = 0; n < 4; n++) bd[32*n +: 32] = dw[4*sent + n];
            bus.i_wr_valid = v;
            bus.i_wr_data  = bd;

            @(negedge clk);
            chk({nm, "_busy"},  128'(bus.o_wr_busy),  128'd1);
            chk({nm, "_ready"}, 128'(bus.o_wr_ready), 128'(sent < beats));
            chk({nm, "_wr_en"}, 128'(bus.o_bar_wr_en), 128'(exp_en));
            chk({nm, "_err"},   128'(bus.o_wr_err),   128'(exp_err));
            if (exp_en) begin
                chk({nm, "_addr"},    128'(bus.o_bar_wr_addr),    128'(ea[wrote]));
                chk({nm, "_byte_en"}, 128'(bus.o_bar_wr_byte_en), 128'(eb[wrote]));
                chk({nm, "_data"},    bus.o_bar_wr_data & em[wrote], ed[wrote]);
                chk({nm, "_done"},    128'(bus.o_wr_done), 128'(wrote == words - 1));
                if (bus.o_wr_done) done_it = it;
                wrote++;
            end else begin
                chk({nm, "_done"}, 128'(bus.o_wr_done), 128'd0);
            end

            exp_err = inj_now;
            if (v) begin
                sent++;
                exp_en = 1'b1;
                if (sent == beats && flush == 1) pend = 1'b1;
            end else if (pend) begin
                exp_en = 1'b1;
                pend   = 1'b0;
            end else begin
                exp_en = 1'b0;
            end
            @(posedge clk); #1;
            it++;
        end
        drive_idle();
        chk({nm, "_timeout"}, 128'(wrote), 128'(words));
        chk({nm, "_latency"}, 128'(done_it + 1), 128'(beats + gaps + flush + 1));
        @(negedge clk);
        chk({nm, "_busy_fall"}, 128'(bus.o_wr_busy),   128'd0);
        chk({nm, "_idle_wr"},   128'(bus.o_bar_wr_en), 128'd0);
        chk({nm, "_idle_rdy"},  128'(bus.o_wr_ready),  128'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_burst("t1_aligned",    11'h010, 10'd4, 4'hF, 4'hF, 0,  1'b0, 1'b0);
        run_burst("t2_off1_len5",  11'h001, 10'd5, 4'hC, 4'h3, 0,  1'b0, 1'b0);
        run_burst("t3_len1024",    11'h000, 10'd0, 4'hF, 4'hF, 25, 1'b0, 1'b0);
        run_burst("t4_wrap",       11'h7FE, 10'd4, 4'hF, 4'hF, 0,  1'b0, 1'b0);
        run_burst("t5_len1",       11'h003, 10'd1, 4'h6, 4'hF, 0,  1'b0, 1'b0);
        run_burst("t6_start_data", 11'h102, 10'd12, 4'h8, 4'h1, 10, 1'b1, 1'b0);
        run_burst("t6_start_vld",  11'h041, 10'd7, 4'hE, 4'h7, 0,  1'b0, 1'b1);

        // Valid while IDLE: dropped, error pulse, no write
        @(posedge clk); #1;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.i_wr_valid = 1'b0;
        @(negedge clk);
        chk("idle_valid_err",   128'(bus.o_wr_err),    128'd1);
        chk("idle_valid_wr_en", 128'(bus.o_bar_wr_en), 128'd0);
        @(negedge clk);
        chk("idle_valid_err_clr", 128'(bus.o_wr_err), 128'd0);

        // Reset in the middle of a burst
        @(posedge clk); #1;
        bus.i_wr_start  = 1'b1;
        bus.i_wr_addr   = 11'h020;
        bus.i_wr_length = 10'd16;
        bus.i_first_be  = 4'hF;
        bus.i_last_be   = 4'hF;
        @(posedge clk); #1;
        bus.i_wr_start = 1'b0;
        bus.i_wr_valid = 1'b1;
        bus.i_wr_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.i_wr_data  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        bus.i_wr_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_wr_en", 128'(bus.o_bar_wr_en),   128'd1);
        chk("rst_pre_addr",  128'(bus.o_bar_wr_addr), 128'h9);
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.i_wr_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_post_wr_en", 128'(bus.o_bar_wr_en), 128'd0);
            chk("rst_post_busy",  128'(bus.o_wr_busy),   128'd0);
            chk("rst_post_ready", 128'(bus.o_wr_ready),  128'd0);
            @(posedge clk); #1;
        end
        bus.i_wr_valid = 1'b0;
        @(posedge clk); #1;

        // Randomized bursts
        for (int r = 0; r < 10; r++) begin
            run_burst("rand", 11'($urandom_range(0, 2047)), 10'($urandom_range(1, 40)),
                      4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 20, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
